// File: rtl/compteur_pkg.sv
// Shared definitions for the compteur counter library: state encoding and default width.
package compteur_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_t;

    localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/dec_bin.sv
// Combinational ripple decrementer built from half-subtractor cells.
// Outputs val-1 and a flag that is high when val==1, i.e. when the result is zero.
module dec_bin #(
    parameter int unsigned WIDTH = compteur_pkg::DefaultWidth
) (
    input  logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] dec,
    output logic             is_one
);

    // borrow[i] is the borrow into bit i; subtracting 1 means bit 0 always borrows.
    logic [WIDTH-1:0] borrow;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign dec[i] = val[i] ^ borrow[i];
        if (i < WIDTH - 1) begin : g_borrow
            assign borrow[i+1] = ~val[i] & borrow[i];
        end
    end

    assign is_one = ~|dec;

endmodule

// File: rtl/decpt_bin8.sv
// Loadable binary down-counter with terminal-count pulse and optional auto-reload.
// Count-down counterpart of cpt_bin8, used as a timeout/interval timer.
module decpt_bin8
    import compteur_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             activate,
    output logic [WIDTH-1:0] cpt,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cpt_q, cpt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] cpt_dec;
    logic             cpt_is_one;

    dec_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .val    (cpt_q),
        .dec    (cpt_dec),
        .is_one (cpt_is_one)
    );

    always_comb begin
        state_d = state_q;
        cpt_d   = cpt_q;
        rld_d   = rld_q;
        done_d  = 1'b0;

        if (clr) begin
            cpt_d   = '0;
            state_d = StIdle;
        end else if (load) begin
            rld_d = load_val;
            if (load_val != '0) begin
                cpt_d   = load_val;
                state_d = StRun;
            end else begin
                // A zero start value is an immediate terminal count.
                cpt_d   = '0;
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end else if (state_q == StRun && activate) begin
            if (cpt_is_one) begin
                done_d = 1'b1;
                if (AUTO_RELOAD) begin
                    // rld is non-zero whenever RUN was entered through a load.
                    cpt_d = rld_q;
                end else begin
                    cpt_d   = '0;
                    state_d = StIdle;
                end
            end else begin
                cpt_d = cpt_dec;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cpt_q   <= '0;
            rld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cpt_q   <= cpt_d;
            rld_q   <= rld_d;
            done_q  <= done_d;
        end
    end

    assign cpt  = cpt_q;
    assign busy = (state_q == StRun);
    assign done = done_q;

endmodule
